// File: rtl/mod_mult_pre_br_if.sv
// Operand/product bus of the pre-Barrett multiplier, including the
// pipeline control strobes (en, flush) that travel with it.
interface mod_mult_pre_br_if #(
    parameter int DATA_WIDTH = 22,
    parameter int TAG_WIDTH  = 16
);
    localparam int DDW = 2 * DATA_WIDTH;

    logic                  en;
    logic                  flush;
    logic [DATA_WIDTH-1:0] A_in;
    logic [DATA_WIDTH-1:0] B_in;
    logic                  in_valid;
    logic [TAG_WIDTH-1:0]  tag_in;
    logic [DDW-1:0]        S_out;
    logic                  out_valid;
    logic [TAG_WIDTH-1:0]  tag_out;
    logic                  out_err;

    // Producer side: drives operands and control, observes the product
    modport master (
        output en, flush, A_in, B_in, in_valid, tag_in,
        input  S_out, out_valid, tag_out, out_err
    );

    // Multiplier side
    modport slave (
        input  en, flush, A_in, B_in, in_valid, tag_in,
        output S_out, out_valid, tag_out, out_err
    );
endinterface

// File: rtl/mod_mult_pre_br.sv
// Two-stage 22x22 multiplier feeding the Barrett reducer. Stage 1 forms the
// four 11x11 limb partial products and the operand range flag; stage 2
// aligns and sums them into the 44-bit product. en stalls everything,
// flush drops every valid bit in flight.
module mod_mult_pre_br #(
    parameter int          DATA_WIDTH        = 22,
    parameter int          DOUBLE_DATA_WIDTH = 44,
    parameter int          HALF_WIDTH        = 11,
    parameter int          TAG_WIDTH         = 16,
    parameter int unsigned Prime             = 2162623
) (
    input  logic                clk,
    input  logic                rst,
    mod_mult_pre_br_if.slave    bus
);
    localparam int STAGES = 2;
    localparam int MIDW   = DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] PRIME_W = Prime[DATA_WIDTH-1:0];

    // Limbs: index 1 = high half, index 0 = low half
    logic [1:0][HALF_WIDTH-1:0] a_l, b_l;
    assign a_l = bus.A_in;
    assign b_l = bus.B_in;

    // Partial products, index {a_limb, b_limb}: 3=hh, 2=hl, 1=lh, 0=ll
    logic [3:0][DATA_WIDTH-1:0] pp_d, pp_q;
    for (genvar g = 0; g < 4; g++) begin : g_pp
        assign pp_d[g] = {{HALF_WIDTH{1'b0}}, a_l[g/2]} * {{HALF_WIDTH{1'b0}}, b_l[g%2]};
    end

    logic                  err_d, err1_q;
    logic [TAG_WIDTH-1:0]  tag1_q, tag_out_q;
    logic                  out_err_q;
    logic [STAGES:1]       vld_pipe_q;
    logic [DOUBLE_DATA_WIDTH-1:0] s_d, s_q;
    logic [MIDW-1:0]       mid_d;

    assign err_d = (bus.A_in >= PRIME_W) | (bus.B_in >= PRIME_W);

    // Cross terms share the same weight; add them once at 23 bits
    assign mid_d = {1'b0, pp_q[2]} + {1'b0, pp_q[1]};

    // The 45-bit sum never sets its top bit for 22-bit operands, so it is
    // formed directly at 44 bits (wrap-around equals dropping bit 44).
    assign s_d = {pp_q[3], {DATA_WIDTH{1'b0}}}
               + {{(DOUBLE_DATA_WIDTH-MIDW-HALF_WIDTH){1'b0}}, mid_d, {HALF_WIDTH{1'b0}}}
               + {{(DOUBLE_DATA_WIDTH-DATA_WIDTH){1'b0}}, pp_q[0]};

    // Valid shift register: flush wins over a stall and drops the new input
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe_q <= '0;
        else if (bus.flush)
            vld_pipe_q <= '0;
        else if (bus.en)
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
    end

    // Stage 1 data: loads on every enabled cycle regardless of valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q   <= '0;
            tag1_q <= '0;
            err1_q <= 1'b0;
        end else if (bus.en) begin
            pp_q   <= pp_d;
            tag1_q <= bus.tag_in;
            err1_q <= err_d;
        end
    end

    // Stage 2 data: final product with its sideband
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q       <= '0;
            tag_out_q <= '0;
            out_err_q <= 1'b0;
        end else if (bus.en) begin
            s_q       <= s_d;
            tag_out_q <= tag1_q;
            out_err_q <= err1_q;
        end
    end

    assign bus.S_out     = s_q;
    assign bus.out_valid = vld_pipe_q[STAGES];
    assign bus.tag_out   = tag_out_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_mod_mult_pre_br.sv
// Bench for mod_mult_pre_br: directed corner cases plus a random stream,
// all checked against a two-slot transaction model using plain A*B.
module tb_mod_mult_pre_br;
    localparam longint unsigned PRIME = 2162623;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mod_mult_pre_br_if bus ();
    mod_mult_pre_br dut (.clk(clk), .rst(rst), .bus(bus));

    int errs   = 0;
    int checks = 0;

    typedef struct {
        bit               v;
        longint unsigned  p;
        logic [15:0]      tag;
        bit               e;
    } ent_t;

    ent_t m0, m1;   // model: m0 = one edge old, m1 = output

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input bit v, input longint unsigned a, input longint unsigned b,
                                input logic [15:0] t);
        ent_t r;
        r.v   = v;
        r.p   = (a * b) & 64'h0000_0FFF_FFFF_FFFF;
        r.tag = t;
        r.e   = (a >= PRIME) || (b >= PRIME);
        return r;
    endfunction

    task automatic model_reset();
        m0 = '{0, 0, 16'h0, 0};
        m1 = '{0, 0, 16'h0, 0};
    endtask

    // One clock: model follows the edge, compare at the falling edge
    task automatic step();
        @(posedge clk);
        if (bus.en) begin
            m1 = m0;
            m0 = mk(bus.in_valid, longint'(bus.A_in), longint'(bus.B_in), bus.tag_in);
        end
        if (bus.flush) begin
            m0.v = 0;
            m1.v = 0;
        end
        @(negedge clk);
        chk("out_valid", {63'b0, bus.out_valid}, {63'b0, m1.v});
        if (m1.v) begin
            chk("S_out", {20'b0, bus.S_out}, m1.p);
            chk("tag_out", {48'b0, bus.tag_out}, {48'b0, m1.tag});
            chk("out_err", {63'b0, bus.out_err}, {63'b0, m1.e});
        end
    endtask

    task automatic drive(input logic [21:0] a, input logic [21:0] b, input logic v,
                         input logic [15:0] t, input logic e, input logic f);
        bus.A_in = a; bus.B_in = b; bus.in_valid = v; bus.tag_in = t;
        bus.en = e; bus.flush = f;
    endtask

    function automatic logic [21:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return 22'($urandom);
            1: return 22'(PRIME - 2 + longint'($urandom_range(0, 4)));
            2: begin
                logic [21:0] c [4];
                c = '{22'd2047, 22'd2048, 22'h3FFFFF, 22'h3FF800};
                return c[$urandom_range(0, 3)];
            end
            default: return 22'($urandom_range(0, 2162622));
        endcase
    endfunction

    initial begin
        drive(0, 0, 0, 0, 1, 0);
        model_reset();
        rst = 1'b1;
        #12;
        chk("rst_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_S", {20'b0, bus.S_out}, 64'd0);
        chk("rst_tag", {48'b0, bus.tag_out}, 64'd0);
        chk("rst_err", {63'b0, bus.out_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic product, 2-cycle latency
        drive(1234, 5678, 1, 16'h0001, 1, 0); step();
        drive(0, 0, 0, 0, 1, 0);              step();
        chk("t2_S", {20'b0, bus.S_out}, 64'd7006652);
        chk("t2_v", {63'b0, bus.out_valid}, 64'd1);
        chk("t2_err", {63'b0, bus.out_err}, 64'd0);

        // Limb carry boundaries, streamed back to back
        drive(2162622, 2162622, 1, 16'h0010, 1, 0); step();
        drive(2048, 2048, 1, 16'h0011, 1, 0);       step();
        chk("t3_max", {20'b0, bus.S_out}, 64'd4676933914884);
        drive(2047, 2048, 1, 16'h0012, 1, 0);       step();
        chk("t3_2048", {20'b0, bus.S_out}, 64'd4194304);
        drive(0, 0, 0, 0, 1, 0);                    step();
        chk("t3_2047", {20'b0, bus.S_out}, 64'd4192256);

        // Out-of-range operands still multiply, flagged
        drive(2162623, 1, 1, 16'h0020, 1, 0); step();
        drive(5, 2162624, 1, 16'h0021, 1, 0); step();
        chk("t6a_S", {20'b0, bus.S_out}, 64'd2162623);
        chk("t6a_err", {63'b0, bus.out_err}, 64'd1);
        drive(0, 0, 0, 0, 1, 0);              step();
        chk("t6b_S", {20'b0, bus.S_out}, 64'd10813120);
        chk("t6b_err", {63'b0, bus.out_err}, 64'd1);

        // Async reset with two products in flight
        drive(777, 888, 1, 16'h0030, 1, 0); step();
        drive(999, 111, 1, 16'h0031, 1, 0); step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t1_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("t1_S", {20'b0, bus.S_out}, 64'd0);
        #2 rst = 1'b0;
        drive(0, 0, 0, 0, 1, 0);
        step(); step(); step();

        // Stream of 8 tags, stalls on cycles 3 and 5; junk offered while stalled
        begin
            int k = 0;
            for (int c = 0; c < 12; c++) begin
                bit st = (c == 3) || (c == 5);
                if (st)
                    drive(22'h3ABCDE, 22'h155555, 1, 16'hDEAD, 0, 0);
                else if (k < 8) begin
                    drive(22'(1000 + 37 * k), 22'(2048 + k), 1, 16'(16'h0100 + k), 1, 0);
                    k++;
                end else
                    drive(0, 0, 0, 0, 1, 0);
                step();
            end
        end

        // Flush during a stall with two products in the pipe
        drive(3000, 4000, 1, 16'h0040, 1, 0); step();
        drive(5000, 6000, 1, 16'h0041, 1, 0); step();
        drive(7000, 8000, 1, 16'h0042, 0, 1); step();
        chk("t5_flush", {63'b0, bus.out_valid}, 64'd0);
        drive(123, 456, 1, 16'h0043, 1, 0);   step();
        drive(0, 0, 0, 0, 1, 0);              step();
        chk("t5_after", {20'b0, bus.S_out}, 64'd56088);
        chk("t5_tag", {48'b0, bus.tag_out}, 64'h0043);

        // Random stream
        for (int i = 0; i < 400; i++) begin
            drive(rnd_op(), rnd_op(), 1'($urandom_range(0, 9) < 7), 16'($urandom),
                  1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 19) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
